// File: rtl/conv_window_if.sv
// Pixel-in / window-out bundle between a raster pixel source and conv_window.
// master = pixel source side, slave = window generator side.
interface conv_window_if #(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned WIDTH_BIT = 8,
    parameter int unsigned IMG_W     = 8,
    parameter int unsigned IMG_H     = 8
);
    logic signed [WIDTH_BIT-1:0]                     pix_in;
    logic                                            pix_valid;
    logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_out;
    logic                                            win_valid;
    logic [$clog2(IMG_H)-1:0]                        win_row;
    logic [$clog2(IMG_W)-1:0]                        win_col;
    logic                                            frame_done;

    modport master (
        output pix_in, pix_valid,
        input  win_out, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_in, pix_valid,
        output win_out, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/conv_window.sv
// Streaming SIZE x SIZE window generator. Pixels arrive in raster order, the
// previous SIZE-1 rows live in line buffers, and every fully-inside
// neighbourhood is presented as a registered window one cycle after its
// bottom-right pixel is accepted.
module conv_window #(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned WIDTH_BIT = 8,
    parameter int unsigned IMG_W     = 8,
    parameter int unsigned IMG_H     = 8
) (
    input logic          clock,
    input logic          reset,
    conv_window_if.slave bus
);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    typedef logic signed [WIDTH_BIT-1:0] pix_t;

    // Line buffers: index 0 holds the oldest row, SIZE-2 the row just above.
    pix_t lbuf [SIZE-1][IMG_W];

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_col, last_row, in_window, accept;
    pix_t          new_col [SIZE];

    pix_t [SIZE-1:0][SIZE-1:0] win_q;
    logic                      win_valid_q;
    logic                      frame_done_q;
    logic [RW-1:0]             win_row_q;
    logic [CW-1:0]             win_col_q;

    // Raster position bookkeeping and the incoming window column.
    always_comb begin
        accept    = bus.pix_valid;
        last_col  = (col_q == CW'(IMG_W - 1));
        last_row  = (row_q == RW'(IMG_H - 1));
        in_window = (row_q >= RW'(SIZE - 1)) && (col_q >= CW'(SIZE - 1));
        col_d     = last_col ? '0 : col_q + 1'b1;
        row_d     = row_q;
        if (last_col) begin
            row_d = last_row ? '0 : row_q + 1'b1;
        end
        for (int unsigned k = 0; k < SIZE - 1; k++) begin
            new_col[k] = lbuf[k][col_q];
        end
        new_col[SIZE-1] = bus.pix_in;
    end

    // Line buffers shift up one row at the current column; never reset since
    // the valid rule only exposes entries written in the current frame.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int unsigned k = 0; k + 1 < SIZE - 1; k++) begin
                lbuf[k][col_q] <= lbuf[k+1][col_q];
            end
            lbuf[SIZE-2][col_q] <= bus.pix_in;
        end
    end

    // Counters, window shift register, coordinates and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q        <= '0;
            col_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            win_valid_q  <= accept && in_window;
            frame_done_q <= accept && in_window && last_row && last_col;
            if (accept) begin
                row_q     <= row_d;
                col_q     <= col_d;
                // Coordinates track every pixel; only meaningful when flagged.
                win_row_q <= row_q - RW'(SIZE - 1);
                win_col_q <= col_q - CW'(SIZE - 1);
                for (int unsigned i = 0; i < SIZE; i++) begin
                    for (int unsigned j = 0; j + 1 < SIZE; j++) begin
                        win_q[i][j] <= win_q[i][j+1];
                    end
                    win_q[i][SIZE-1] <= new_col[i];
                end
            end
        end
    end

    assign bus.win_out    = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_conv_window.sv
// Randomized bench for conv_window against an image-array reference model.
module tb_conv_window;
    localparam int unsigned SZ = 3;
    localparam int unsigned WB = 8;
    localparam int unsigned W  = 5;
    localparam int unsigned H  = 4;
    localparam int unsigned WINS_PER_FRAME = (W - SZ + 1) * (H - SZ + 1);

    logic clock = 1'b0;
    logic reset;

    conv_window_if #(.SIZE(SZ), .WIDTH_BIT(WB), .IMG_W(W), .IMG_H(H)) bus ();

    conv_window #(.SIZE(SZ), .WIDTH_BIT(WB), .IMG_W(W), .IMG_H(H)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the current frame as a plain image plus raster position.
    logic [WB-1:0] img [H][W];
    int            m_row, m_col;
    bit            have_win;
    logic [127:0]  last_win;
    int            last_r, last_c;
    int            win_cnt;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_row    = 0;
        m_col    = 0;
        have_win = 1'b1;
        last_win = '0;
        last_r   = 0;
        last_c   = 0;
        win_cnt  = 0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_win_valid", 128'(bus.win_valid), 128'(0));
        check_eq("rst_frame_done", 128'(bus.frame_done), 128'(0));
        check_eq("rst_win_out", 128'($unsigned(bus.win_out)), 128'(0));
        check_eq("rst_win_row", 128'(bus.win_row), 128'(0));
        check_eq("rst_win_col", 128'(bus.win_col), 128'(0));
    endtask

    // One clock: drive, let the edge pass, then compare against the model.
    task automatic step(input bit v, input logic [WB-1:0] p);
        bit           exp_v, exp_d;
        logic [127:0] ew;
        int           er, ec;
        bus.pix_valid = v;
        bus.pix_in    = p;
        @(posedge clock);
        #1;
        exp_v = 1'b0;
        exp_d = 1'b0;
        ew    = '0;
        er    = 0;
        ec    = 0;
        if (v) begin
            img[m_row][m_col] = p;
            if (m_row >= int'(SZ) - 1 && m_col >= int'(SZ) - 1) begin
                exp_v = 1'b1;
                er    = m_row - (int'(SZ) - 1);
                ec    = m_col - (int'(SZ) - 1);
                for (int i = 0; i < int'(SZ); i++)
                    for (int j = 0; j < int'(SZ); j++)
                        ew[(i * int'(SZ) + j) * int'(WB) +: WB] = img[er + i][ec + j];
                exp_d = (m_row == int'(H) - 1) && (m_col == int'(W) - 1);
                win_cnt++;
            end
            m_col++;
            if (m_col == int'(W)) begin
                m_col = 0;
                m_row = (m_row == int'(H) - 1) ? 0 : m_row + 1;
            end
        end
        check_eq("win_valid", 128'(bus.win_valid), 128'(exp_v));
        check_eq("frame_done", 128'(bus.frame_done), 128'(exp_d));
        if (exp_v) begin
            check_eq("win_out", 128'($unsigned(bus.win_out)), ew);
            check_eq("win_row", 128'(bus.win_row), 128'(er));
            check_eq("win_col", 128'(bus.win_col), 128'(ec));
            have_win = 1'b1;
            last_win = ew;
            last_r   = er;
            last_c   = ec;
        end else if (!v && have_win) begin
            check_eq("hold_win_out", 128'($unsigned(bus.win_out)), last_win);
            check_eq("hold_win_row", 128'(bus.win_row), 128'(last_r));
            check_eq("hold_win_col", 128'(bus.win_col), 128'(last_c));
        end else if (v) begin
            have_win = 1'b0;
        end
        if (exp_d) begin
            check_eq("wins_per_frame", 128'(win_cnt), 128'(WINS_PER_FRAME));
            win_cnt = 0;
        end
    endtask

    task automatic gap(input int max_idle);
        int n;
        n = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
        for (int k = 0; k < n; k++) step(1'b0, WB'($urandom));
    endtask

    task automatic random_frame(input int max_idle);
        for (int i = 0; i < int'(W * H); i++) begin
            gap(max_idle);
            step(1'b1, WB'($urandom));
        end
    endtask

    logic [WB-1:0] sign_vals [4];

    initial begin
        sign_vals[0] = 8'h80;
        sign_vals[1] = 8'hFF;
        sign_vals[2] = 8'h7F;
        sign_vals[3] = 8'h00;

        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        reset         = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // Sequential values make any misplaced window entry obvious.
        for (int i = 0; i < int'(W * H); i++) step(1'b1, WB'(i + 1));
        step(1'b0, '0);

        // Same-style frame with random idle gaps.
        random_frame(3);

        // Partial frame up to a flagged window, then asynchronous reset.
        for (int i = 0; i < 2 * int'(W) + 4; i++) step(1'b1, WB'(8'd50 + 8'(i)));
        check_eq("pre_reset_valid", 128'(bus.win_valid), 128'(1));
        reset = 1'b1;
        #1;
        check_reset_outputs();
        bus.pix_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b0, '0);

        // Frame after mid-frame reset starts at (0,0).
        for (int i = 0; i < int'(W * H); i++) step(1'b1, WB'(i + 1));

        // Sign extremes, bit-exact pass-through.
        for (int i = 0; i < int'(W * H); i++) begin
            gap(1);
            step(1'b1, sign_vals[$urandom_range(0, 3)]);
        end

        // Several more back-to-back and gapped frames across wraps.
        random_frame(0);
        random_frame(2);
        random_frame(3);
        repeat (3) step(1'b0, WB'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
